lsu_mem_ctrl: RTL and testbench

Sequential load/store unit between the execute stage and a synchronous memory port; replaces the combinational, zero-latency pmem access with a valid/ready request/response protocol. One access outstanding at a time, variable memory latency. Handles byte-lane alignment, write strobes, load sign/zero extension, misalignment detection and a memory-response timeout.

---
 rtl/lsu_mem_ctrl.sv | 119 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store unit with valid/ready memory port, lane alignment, extension and timeout
module lsu_mem_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_wen,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_misalign,
    output logic                resp_fault,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic                wen;
    logic [1:0]          size;
    logic                uns;
    logic [DATA_W-1:0]   wdata;
    logic [CNT_W-1:0]    cnt;
    logic [OFF_W-1:0]    off;
    logic [6:0]          nbits;
    logic [NB-1:0]       bmask;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   lmask;
    logic [DATA_W-1:0]   ext;
    logic                sign;
    logic                bad;

    // lmask keeps the access-sized low bits; its top set bit locates the sign bit
    always_comb begin
        off     = addr[OFF_W-1:0];
        nbits   = 7'd8 << size;
        bmask   = ~({NB{1'b1}} << (4'd1 << size));
        shifted = mem_rdata >> {off, 3'b000};
        lmask   = {DATA_W{1'b1}} >> (7'(DATA_W) - nbits);
        sign    = |(shifted & lmask & ~(lmask >> 1));
        ext     = (shifted & lmask) | (sign && !uns ? ~lmask : '0);
        bad     = ((5'd1 << req_size) > 5'(NB)) ||
                  ((req_addr[3:0] & ((4'd1 << req_size) - 4'd1)) != 4'd0);
    end

    assign req_ready     = state == IDLE;
    assign resp_valid    = state == RESP;
    assign mem_req_valid = state == REQ;
    assign mem_addr      = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_wen       = wen;
    assign mem_wdata     = wdata << {off, 3'b000};
    assign mem_wstrb     = wen ? bmask << off : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            wen           <= 1'b0;
            size          <= 2'd0;
            uns           <= 1'b0;
            wdata         <= '0;
            cnt           <= '0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
            resp_fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr          <= req_addr;
                    wen           <= req_wen;
                    size          <= req_size;
                    uns           <= req_unsigned;
                    wdata         <= req_wdata;
                    resp_misalign <= bad;
                    state         <= bad ? RESP : REQ;
                end
                REQ: if (mem_req_ready) begin
                    cnt   <= '0;
                    state <= wen ? RESP : WAIT;
                end
                WAIT: if (mem_rvalid) begin
                    resp_rdata <= ext;
                    state      <= RESP;
                end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
                    resp_fault <= 1'b1;
                    state      <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (resp_ready) begin
                    resp_rdata    <= '0;
                    resp_misalign <= 1'b0;
                    resp_fault    <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: vector table, timeout/reset sequences and randomized ops against a byte-level memory model
module tb_lsu_mem_ctrl;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_misalign;
    logic        resp_fault;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    lsu_mem_ctrl #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .resp_fault(resp_fault),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] ref_mem [256];

    // memory responder: stalls, latency, spurious rvalid; records handshakes
    int          mrr_stall = 0;
    int          rd_lat = 0;
    logic        noise = 1'b0;
    logic [63:0] dmem [32];
    logic        mem_init = 1'b0;
    logic        rd_pend = 1'b0;
    int          rd_dly = 0;
    logic [63:0] rd_word = '0;
    logic        in_req = 1'b0;
    int          stall_left = 0;
    logic [136:0] first_req = '0;
    int          hs_n = 0;
    int          stab_err = 0;
    logic [63:0] hs_addr = '0;
    logic        hs_wen = 1'b0;
    logic [63:0] hs_wdata = '0;
    logic [7:0]  hs_strb = '0;

    always @(negedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++)
                for (int b = 0; b < 8; b++) dmem[i][8*b +: 8] = ref_mem[8*i+b];
            mem_init = 1'b1;
        end
        mem_rvalid = 1'b0;
        if (rd_pend) begin
            if (rd_dly == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_word;
                rd_pend    = 1'b0;
            end else rd_dly--;
        end else if (noise && $urandom_range(0, 3) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = {$urandom, $urandom};
        end
        if (mem_req_valid) begin
            if (!in_req) begin
                in_req     = 1'b1;
                stall_left = mrr_stall;
                first_req  = {mem_addr, mem_wen, mem_wdata, mem_wstrb};
            end else if ({mem_addr, mem_wen, mem_wdata, mem_wstrb} !== first_req) stab_err++;
            if (stall_left > 0) begin
                mem_req_ready = 1'b0;
                stall_left--;
            end else begin
                mem_req_ready = 1'b1;
                in_req   = 1'b0;
                hs_n++;
                hs_addr  = mem_addr;
                hs_wen   = mem_wen;
                hs_wdata = mem_wdata;
                hs_strb  = mem_wstrb;
                if (mem_wen) begin
                    for (int b = 0; b < 8; b++)
                        if (mem_wstrb[b]) dmem[mem_addr[7:3]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else if (rd_lat >= 0) begin
                    rd_pend = 1'b1;
                    rd_dly  = rd_lat;
                    rd_word = dmem[mem_addr[7:3]];
                end
            end
        end else begin
            mem_req_ready = 1'($urandom_range(0, 1));
            in_req = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic ref_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[a[7:0] + i] = wd[8*i +: 8];
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input logic u);
        logic [63:0] v = '0;
        int nb = 8 << sz;
        for (int i = 0; i < (1 << sz); i++) v |= 64'(ref_mem[a[7:0] + i]) << (8 * i);
        if (!u && nb < 64 && v[nb-1]) v |= {64{1'b1}} << nb;
        return v;
    endfunction

    // one access from an idle unit; caller supplies every expected value
    task automatic check_op(input string tag, input logic [63:0] a, input logic w, input logic [1:0] sz,
                            input logic u, input logic [63:0] wd, input int ms, input int rs, input int dl,
                            input logic [63:0] e_rd, input logic e_mis, input logic e_flt,
                            input logic [63:0] e_maddr, input logic [63:0] e_mwd, input logic [7:0] e_strb,
                            input int e_lat);
        int hs0 = hs_n;
        int se0 = stab_err;
        int lat;
        logic [63:0] rd;
        logic mis, flt, hold;
        mrr_stall = ms;
        rd_lat    = dl;
        req_valid = 1'b1; req_addr = a; req_wen = w; req_size = sz; req_unsigned = u; req_wdata = wd;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        req_valid = 1'b0;
        while (!resp_valid && lat < 100) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        rd = resp_rdata; mis = resp_misalign; flt = resp_fault;
        hold = resp_valid && !req_ready;
        for (int i = 0; i < rs; i++) begin
            @(negedge clock);
            hold &= resp_valid && !req_ready && resp_rdata === rd && resp_misalign === mis && resp_fault === flt;
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        hold &= !resp_valid && req_ready && !resp_misalign && !resp_fault && resp_rdata == '0;
        chk({tag, " rdata"}, rd, e_rd);
        chk({tag, " misalign"}, 64'(mis), 64'(e_mis));
        chk({tag, " fault"}, 64'(flt), 64'(e_flt));
        chk({tag, " latency"}, 64'(lat), 64'(e_lat));
        chk({tag, " mem_requests"}, 64'(hs_n - hs0), e_mis ? 64'd0 : 64'd1);
        chk({tag, " resp_hold"}, 64'(hold), 64'd1);
        chk({tag, " mem_stable"}, 64'(stab_err - se0), 64'd0);
        if (!e_mis) begin
            chk({tag, " mem_addr"}, hs_addr, e_maddr);
            chk({tag, " mem_wen"}, 64'(hs_wen), 64'(w));
            chk({tag, " mem_wstrb"}, 64'(hs_strb), 64'(e_strb));
            if (w) begin
                chk({tag, " mem_wdata"}, hs_wdata, e_mwd);
                ref_store(a, sz, wd);
            end
        end
    endtask

    typedef struct {
        logic [63:0] a; logic w; logic [1:0] sz; logic u; logic [63:0] wd; int ms; int rs;
        logic [63:0] e_rd; logic e_mis; logic [63:0] e_maddr; logic [63:0] e_mwd; logic [7:0] e_strb; int e_lat;
    } vec_t;
    vec_t tbl [13];

    initial begin
        logic [63:0] a, wd, e_rd, e_mwd;
        logic [15:0] sm;
        logic [1:0] sz;
        logic w, u, mis;
        int nb, o, ms, rs, dl, hs0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        tbl[0]  = '{BASE + 64'h05, 1'b1, 2'd0, 1'b0, 64'hAB, 0, 0, 64'h0, 1'b0, BASE, 64'h0000_AB00_0000_0000, 8'h20, 2};
        tbl[1]  = '{BASE + 64'h00, 1'b1, 2'd3, 1'b0, 64'h8765_4321_0000_0000, 0, 0, 64'h0, 1'b0, BASE, 64'h8765_4321_0000_0000, 8'hFF, 2};
        tbl[2]  = '{BASE + 64'h04, 1'b0, 2'd2, 1'b0, 64'h0, 0, 0, 64'hFFFF_FFFF_8765_4321, 1'b0, BASE, 64'h0, 8'h00, 3};
        tbl[3]  = '{BASE + 64'h04, 1'b0, 2'd2, 1'b1, 64'h0, 0, 1, 64'h0000_0000_8765_4321, 1'b0, BASE, 64'h0, 8'h00, 3};
        tbl[4]  = '{BASE + 64'h06, 1'b0, 2'd1, 1'b0, 64'h0, 0, 0, 64'hFFFF_FFFF_FFFF_8765, 1'b0, BASE, 64'h0, 8'h00, 3};
        tbl[5]  = '{BASE + 64'h07, 1'b0, 2'd0, 1'b1, 64'h0, 0, 0, 64'h87, 1'b0, BASE, 64'h0, 8'h00, 3};
        tbl[6]  = '{BASE + 64'h04, 1'b0, 2'd0, 1'b0, 64'h0, 0, 0, 64'h21, 1'b0, BASE, 64'h0, 8'h00, 3};
        tbl[7]  = '{BASE + 64'h03, 1'b0, 2'd1, 1'b0, 64'h0, 0, 0, 64'h0, 1'b1, BASE, 64'h0, 8'h00, 1};
        tbl[8]  = '{BASE + 64'h04, 1'b1, 2'd3, 1'b0, 64'h1234, 0, 2, 64'h0, 1'b1, BASE, 64'h0, 8'h00, 1};
        tbl[9]  = '{BASE + 64'h0A, 1'b1, 2'd1, 1'b0, 64'hFFFF_1234, 4, 3, 64'h0, 1'b0, BASE + 64'h08, 64'h0000_FFFF_1234_0000, 8'h0C, 6};
        tbl[10] = '{BASE + 64'h0A, 1'b0, 2'd1, 1'b0, 64'h0, 4, 3, 64'h1234, 1'b0, BASE + 64'h08, 64'h0, 8'h00, 7};
        tbl[11] = '{BASE + 64'h00, 1'b0, 2'd3, 1'b1, 64'h0, 0, 0, 64'h8765_4321_0000_0000, 1'b0, BASE, 64'h0, 8'h00, 3};
        tbl[12] = '{BASE + 64'h0B, 1'b0, 2'd0, 1'b0, 64'h0, 0, 0, 64'h12, 1'b0, BASE + 64'h08, 64'h0, 8'h00, 3};

        req_valid = 1'b1; req_addr = BASE; req_wen = 1'b1; req_size = 2'd3;
        repeat (2) begin
            @(negedge clock);
            chk("reset req_ready", 64'(req_ready), 64'd1);
            chk("reset resp_valid", 64'(resp_valid), 64'd0);
            chk("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
        end
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clock);
        chk("post-reset idle", {61'd0, req_ready, resp_valid, mem_req_valid}, 64'b100);
        chk("post-reset no mem request", 64'(hs_n), 64'd0);
        chk("post-reset rdata", resp_rdata, 64'd0);

        for (int i = 0; i < 13; i++)
            check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].wd, tbl[i].ms,
                     tbl[i].rs, 0, tbl[i].e_rd, tbl[i].e_mis, 1'b0, tbl[i].e_maddr, tbl[i].e_mwd,
                     tbl[i].e_strb, tbl[i].e_lat);

        check_op("timeout", BASE + 64'h04, 1'b0, 2'd2, 1'b0, 64'h0, 0, 1, -1,
                 64'h0, 1'b0, 1'b1, BASE, 64'h0, 8'h00, 6);
        check_op("rvalid on last wait cycle", BASE + 64'h04, 1'b0, 2'd2, 1'b0, 64'h0, 0, 0, 3,
                 64'hFFFF_FFFF_8765_4321, 1'b0, 1'b0, BASE, 64'h0, 8'h00, 6);
        check_op("rvalid third wait cycle", BASE + 64'h06, 1'b0, 2'd1, 1'b1, 64'h0, 1, 0, 2,
                 64'h8765, 1'b0, 1'b0, BASE, 64'h0, 8'h00, 6);

        hs0 = hs_n;
        rd_lat = -1; mrr_stall = 0;
        req_valid = 1'b1; req_addr = BASE; req_wen = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid-op reset idle", {61'd0, req_ready, resp_valid, mem_req_valid}, 64'b100);
        repeat (6) @(negedge clock);
        chk("mid-op reset no response", 64'(resp_valid), 64'd0);
        chk("mid-op reset mem requests", 64'(hs_n - hs0), 64'd1);

        noise = 1'b1;
        for (int n = 0; n < 150; n++) begin
            sz = 2'($urandom_range(0, 3));
            nb = 1 << sz;
            o  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) o = o & ~(nb - 1);
            a  = BASE + 64'(o);
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            ms = $urandom_range(0, 2);
            rs = $urandom_range(0, 2);
            dl = $urandom_range(0, 3);
            mis = (o % nb) != 0;
            sm = (16'd1 << nb) - 16'd1;
            e_mwd = wd << (8 * (o % 8));
            e_rd = (mis || w) ? 64'h0 : ref_load(a, sz, u);
            check_op($sformatf("rand%0d", n), a, w, sz, u, wd, ms, rs, dl, e_rd, mis, 1'b0,
                     a & ~64'h7, e_mwd, w ? 8'(sm << (o % 8)) : 8'h00,
                     mis ? 1 : (w ? 2 + ms : 3 + ms + dl));
        end
        noise = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
